mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
// - Memory-access pipeline stage between EX and WB: latches the EX payload, waits for the data-SRAM
//   response of loads/stores, aligns and extends load data, and forwards {pc,gr_we,dest,final_result} to WB.
// - Drives the MEM by-path forwarding bus to ID. One instruction in flight.
// PARAMETERS
// - ES_TO_MS_BUS_WD  75  {pc[31:0],res_from_mem,mem_req,load_op[2:0],gr_we,dest[4:0],alu_result[31:0]}
// - MS_TO_WS_BUS_WD  70  {pc[31:0],gr_we,dest[4:0],final_result[31:0]}
// - MS_FW_BUS_WD     38  {we,dest[4:0],data[31:0]}; 39 with MS_FW_PENDING_EN (pending bit prepended)
// PORTS
// - clk                clk                 in   1    clock, all state on posedge
// - resetn             in   1    synchronous, active-low reset
// - es_to_ms_valid     in   1    EX holds a valid instruction
// - es_to_ms_bus       in   ES_TO_MS_BUS_WD  EX payload
// - ms_allowin         out  1    MEM accepts a new instruction this cycle
// - data_sram_data_ok  in   1    data-SRAM response valid (one pulse per mem_req)
// - data_sram_rdata    in   32   read data, valid with data_ok
// - ws_allowin         in   1    WB accepts
// - ms_to_ws_valid     out  1    MEM output valid
// - ms_to_ws_bus       out  MS_TO_WS_BUS_WD  payload to WB
// - ms_fw_bus          out  MS_FW_BUS_WD     forwarding to ID
// BEHAVIOUR
// - Reset (resetn=0 at posedge): ms_valid=0, payload reg=0, data_got=0, rdata_buf=0; hence
//   ms_to_ws_valid=0, ms_allowin=1, ms_fw_bus=0 the next cycle.
// - Capture: ms_allowin & es_to_ms_valid -> payload reg <= es_to_ms_bus, data_got <= 0.
//   ms_valid <= es_to_ms_valid whenever ms_allowin.
// - Response FSM per instruction: NOREQ (mem_req=0), WAIT (mem_req & ~data_got), GOT (data_got=1).
//   WAIT & data_sram_data_ok -> GOT: rdata_buf <= data_sram_rdata, data_got <= 1.
//   Leaves GOT/NOREQ only by handing off to WB (capture resets data_got).
// - ms_ready_go = ~mem_req | data_got | data_sram_data_ok (same-cycle response passes combinationally,
//   using data_sram_rdata directly; otherwise rdata_buf).
// - ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin); ms_to_ws_valid = ms_valid & ms_ready_go.
// - Latency: non-memory op 1 cycle; load/store = cycles until data_ok (min 1, same cycle).
// - WB stall: response arriving while ws_allowin=0 is held in rdata_buf; never lost, never re-requested.
// - data_ok while ms_valid=0 or state≠WAIT: ignored (bench asserts it never happens).
// - Load extraction, off=alu_result[1:0]: byte=rdata[8*off+:8], half=rdata[16*off[1]+:16];
//   load_op 000 ld.w, 001 ld.b (sext), 010 ld.h (sext), 101 ld.bu (zext), 110 ld.hu (zext);
//   other encodings -> word. Unaligned h/w not checked here (EX raises ALE).
// - final_result = res_from_mem ? extended load data : alu_result. Stores: gr_we=0 from EX.
// - ms_to_ws_bus = {pc,gr_we,dest,final_result}, driven from payload reg regardless of valid.
// - ms_fw_bus = {ms_valid & gr_we, dest, final_result}; dest=0 still reported (ID ignores r0).
// CONFIGURATION
// - MS_FW_PENDING_EN defined: ms_fw_bus gains MSB pending = ms_valid & res_from_mem & ~ms_ready_go
//   (39 bits); ID stalls only while pending, else takes data from bus.
// - Not defined: 38-bit bus; data field invalid for a waiting load, ID must stall on any MEM load hit.
// TESTING
// - Reset: hold resetn=0 2 cycles with es_to_ms_valid=1 -> ms_to_ws_valid=0, ms_allowin=1, fw bus=0.
// - ALU op pc=0x1c000000, dest=4, alu=0x12345678, ws_allowin=1 -> next cycle ms_to_ws_valid=1,
//   bus={0x1c000000,1,4,0x12345678}, fw we=1.
// - ld.b off=3, rdata=0x80FF0011 with data_ok same cycle -> final_result=0xFFFFFF80; ld.hu off=2 -> 0x000080FF.
// - ld.w, data_ok 3 cycles late -> ms_to_ws_valid=0, ms_allowin=0 for 3 cycles, then result=rdata.
// - data_ok arrives while ws_allowin=0 for 2 cycles, rdata changes afterwards -> WB receives buffered value.
// - Back-to-back loads, EX valid every cycle, data_ok each cycle -> one instruction per cycle, no drops.

Source files
------------

// File: rtl/mem_stage_if.sv
// EX/MEM/WB handshake, data-SRAM response and ID forwarding signals of the MEM stage.
// MS_FW_PENDING_EN widens ms_fw_bus by a leading pending bit.
interface mem_stage_if;
  localparam int ES_WD = 75;
  localparam int WS_WD = 70;
`ifdef MS_FW_PENDING_EN
  localparam int FW_WD = 39;
`else
  localparam int FW_WD = 38;
`endif

  logic             es_to_ms_valid;
  logic [ES_WD-1:0] es_to_ms_bus;
  logic             ms_allowin;
  logic             data_sram_data_ok;
  logic [31:0]      data_sram_rdata;
  logic             ws_allowin;
  logic             ms_to_ws_valid;
  logic [WS_WD-1:0] ms_to_ws_bus;
  logic [FW_WD-1:0] ms_fw_bus;

  modport master (
    output es_to_ms_valid, es_to_ms_bus,
    output data_sram_data_ok, data_sram_rdata,
    output ws_allowin,
    input  ms_allowin, ms_to_ws_valid,
    input  ms_to_ws_bus, ms_fw_bus
  );

  modport slave (
    input  es_to_ms_valid, es_to_ms_bus,
    input  data_sram_data_ok, data_sram_rdata,
    input  ws_allowin,
    output ms_allowin, ms_to_ws_valid,
    output ms_to_ws_bus, ms_fw_bus
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the data-SRAM response, aligns load data, feeds WB and ID.
// Optional MS_FW_PENDING_EN adds a load-pending bit as MSB of ms_fw_bus.
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  mem_stage_if.slave  ms
);
  typedef enum logic [1:0] {
    NOREQ,
    WAIT,
    GOT
  } rsp_e;

  logic        valid_q, valid_d;
  logic [74:0] pl_q, pl_d;
  rsp_e        st_q, st_d;
  logic [31:0] rbuf_q, rbuf_d;

  logic [31:0] pc;
  logic        res_from_mem;
  logic        mem_req;
  logic [2:0]  load_op;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;

  assign pc           = pl_q[74:43];
  assign res_from_mem = pl_q[42];
  assign mem_req      = pl_q[41];
  assign load_op      = pl_q[40:38];
  assign gr_we        = pl_q[37];
  assign dest         = pl_q[36:32];
  assign alu_result   = pl_q[31:0];

  logic ready_go;
  logic allowin;

  assign ready_go = ~mem_req | (st_q == GOT)
                  | ms.data_sram_data_ok;
  assign allowin  = ~valid_q
                  | (ready_go & ms.ws_allowin);

  always_comb begin
    valid_d = valid_q;
    pl_d    = pl_q;
    st_d    = st_q;
    rbuf_d  = rbuf_q;
    if (allowin) begin
      valid_d = ms.es_to_ms_valid;
      if (ms.es_to_ms_valid) begin
        pl_d = ms.es_to_ms_bus;
        st_d = ms.es_to_ms_bus[41] ? WAIT : NOREQ;
      end
    end else if (valid_q && st_q == WAIT
                 && ms.data_sram_data_ok) begin
      // WB stalled: hold the response until handoff
      st_d   = GOT;
      rbuf_d = ms.data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      pl_q    <= '0;
      st_q    <= NOREQ;
      rbuf_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pl_q    <= pl_d;
      st_q    <= st_d;
      rbuf_q  <= rbuf_d;
    end
  end

  logic [31:0] rsel;
  logic [1:0]  off;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;
  logic [31:0] final_result;
  logic        op_b, op_h, op_bu, op_hu;

  assign rsel  = (st_q == GOT) ? rbuf_q
                               : ms.data_sram_rdata;
  assign off   = alu_result[1:0];
  assign ld_b  = rsel[{off, 3'b000} +: 8];
  assign ld_h  = off[1] ? rsel[31:16] : rsel[15:0];
  assign op_b  = (load_op == 3'b001);
  assign op_h  = (load_op == 3'b010);
  assign op_bu = (load_op == 3'b101);
  assign op_hu = (load_op == 3'b110);

  always_comb begin
    ld_data = rsel;
    unique case (1'b1)
      op_b:    ld_data = {{24{ld_b[7]}}, ld_b};
      op_h:    ld_data = {{16{ld_h[15]}}, ld_h};
      op_bu:   ld_data = {24'd0, ld_b};
      op_hu:   ld_data = {16'd0, ld_h};
      default: ld_data = rsel;
    endcase
  end

  assign final_result = res_from_mem ? ld_data
                                     : alu_result;

  assign ms.ms_allowin     = allowin;
  assign ms.ms_to_ws_valid = valid_q & ready_go;
  assign ms.ms_to_ws_bus   = {pc, gr_we, dest,
                              final_result};
`ifdef MS_FW_PENDING_EN
  assign ms.ms_fw_bus = {valid_q & res_from_mem & ~ready_go,
                         valid_q & gr_we, dest,
                         final_result};
`else
  assign ms.ms_fw_bus = {valid_q & gr_we, dest,
                         final_result};
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations,
// then randomized traffic checked against an instruction-level model.
module tb_mem_stage;
`ifdef MS_FW_PENDING_EN
  localparam int FW = 39;
`else
  localparam int FW = 38;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if bif ();
  mem_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .ms     (bif)
  );

  typedef struct {
    logic [31:0] pc;
    logic        res;
    logic        mreq;
    logic [2:0]  op;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] alu;
  } ins_t;

  int total = 0;
  int bad = 0;

  ins_t        m_ins;
  bit          m_valid = 0;
  bit          m_got = 0;
  logic [31:0] m_buf = '0;
  int          m_wait = 0;

  logic          s_valid, s_allowin;
  logic [69:0]   s_bus;
  logic [FW-1:0] s_fw;

  function automatic ins_t mk(logic [31:0] pc, logic res, logic mreq,
                              logic [2:0] op, logic we, logic [4:0] dest,
                              logic [31:0] alu);
    ins_t i;
    i.pc = pc; i.res = res; i.mreq = mreq; i.op = op;
    i.we = we; i.dest = dest; i.alu = alu;
    return i;
  endfunction

  function automatic logic [74:0] pack(ins_t i);
    return {i.pc, i.res, i.mreq, i.op, i.we, i.dest, i.alu};
  endfunction

  function automatic logic [31:0] ext(logic [31:0] rd, logic [2:0] op,
                                      logic [1:0] off);
    int unsigned b, h;
    b = (rd >> (int'(off) * 8)) & 32'hFF;
    h = (rd >> (int'(off[1]) * 16)) & 32'hFFFF;
    case (op)
      3'b001: return (b >= 128) ? b - 256 : b;
      3'b010: return (h >= 32768) ? h - 65536 : h;
      3'b101: return b;
      3'b110: return h;
      default: return rd;
    endcase
  endfunction

  task automatic check(string nm, logic [69:0] act, logic [69:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc(bit rn, bit ev, ins_t i, bit ws, bit dok,
                     logic [31:0] rd, bit chk);
    bit rg, e_allow, e_valid;
    logic [31:0] rsel, fin;
    @(negedge clk);
    resetn = rn;
    bif.es_to_ms_valid = ev;
    bif.es_to_ms_bus = pack(i);
    bif.ws_allowin = ws;
    bif.data_sram_data_ok = dok;
    bif.data_sram_rdata = rd;
    #1;
    s_valid = bif.ms_to_ws_valid;
    s_allowin = bif.ms_allowin;
    s_bus = bif.ms_to_ws_bus;
    s_fw = bif.ms_fw_bus;
    rg = !m_ins.mreq || m_got || dok;
    e_allow = !m_valid || (rg && ws);
    e_valid = m_valid && rg;
    rsel = m_got ? m_buf : rd;
    fin = m_ins.res ? ext(rsel, m_ins.op, m_ins.alu[1:0]) : m_ins.alu;
    if (chk) begin
      check("allowin", s_allowin, e_allow);
      check("valid", s_valid, e_valid);
      check("fw_we", s_fw[37], m_valid && m_ins.we);
`ifdef MS_FW_PENDING_EN
      check("fw_pend", s_fw[38], m_valid && m_ins.res && !rg);
`endif
      if (e_valid) begin
        check("ws_bus", s_bus, {m_ins.pc, m_ins.we, m_ins.dest, fin});
        check("fw_data", s_fw[36:0], {m_ins.dest, fin});
      end
    end
    @(posedge clk);
    if (!rn) begin
      m_valid = 0;
      m_ins = mk('0, 0, 0, '0, 0, '0, '0);
      m_got = 0;
      m_buf = '0;
    end else if (e_allow) begin
      m_valid = ev;
      if (ev) begin
        m_ins = i;
        m_got = 0;
        m_wait = $urandom_range(0, 3);
      end
    end else if (m_valid && m_ins.mreq && !m_got && dok) begin
      m_got = 1;
      m_buf = rd;
    end
  endtask

  initial begin
    ins_t nop, alu, lb, lhu, lw, ld[5], r;
    bit ev, ws, dok;
    int k;
    logic [2:0] ops[5];
    m_ins = mk('0, 0, 0, '0, 0, '0, '0);
    nop = mk('0, 0, 0, '0, 0, '0, '0);
    bif.es_to_ms_valid = 0;
    bif.es_to_ms_bus = '0;
    bif.ws_allowin = 1;
    bif.data_sram_data_ok = 0;
    bif.data_sram_rdata = '0;
    alu = mk(32'h1c000000, 0, 0, 3'b000, 1, 5'd4, 32'h12345678);

    cyc(0, 1, alu, 1, 0, '0, 0);
    cyc(0, 1, alu, 1, 0, '0, 1);
    cyc(1, 0, nop, 1, 0, '0, 1);
    check("rst_valid", s_valid, 0);
    check("rst_allowin", s_allowin, 1);
    check("rst_fw", s_fw, 0);

    cyc(1, 1, alu, 1, 0, '0, 1);
    cyc(1, 0, nop, 1, 0, '0, 1);
    check("alu_valid", s_valid, 1);
    check("alu_bus", s_bus, {32'h1c000000, 1'b1, 5'd4, 32'h12345678});
    check("alu_fw_we", s_fw[37], 1);

    lb = mk(32'h1c000004, 1, 1, 3'b001, 1, 5'd5, 32'h00001003);
    cyc(1, 1, lb, 1, 0, '0, 1);
    cyc(1, 0, nop, 1, 1, 32'h80FF0011, 1);
    check("ldb_valid", s_valid, 1);
    check("ldb_res", s_bus[31:0], 32'hFFFFFF80);

    lhu = mk(32'h1c000008, 1, 1, 3'b110, 1, 5'd6, 32'h00002002);
    cyc(1, 1, lhu, 1, 0, '0, 1);
    cyc(1, 0, nop, 1, 1, 32'h80FF0011, 1);
    check("ldhu_res", s_bus[31:0], 32'h000080FF);

    lw = mk(32'h1c00000c, 1, 1, 3'b000, 1, 5'd7, 32'h00003000);
    cyc(1, 1, lw, 1, 0, '0, 1);
    for (int j = 0; j < 3; j++) begin
      cyc(1, 0, nop, 1, 0, $urandom, 1);
      check("lw_wait_valid", s_valid, 0);
      check("lw_wait_allowin", s_allowin, 0);
    end
    cyc(1, 0, nop, 1, 1, 32'hCAFEBABE, 1);
    check("lw_late_valid", s_valid, 1);
    check("lw_late_res", s_bus[31:0], 32'hCAFEBABE);

    lw.pc = 32'h1c000010;
    cyc(1, 1, lw, 1, 0, '0, 1);
    cyc(1, 0, nop, 0, 1, 32'h11223344, 1);
    check("stall_allowin0", s_allowin, 0);
    cyc(1, 0, nop, 0, 0, 32'hDEADBEEF, 1);
    check("stall_valid1", s_valid, 1);
    check("stall_res1", s_bus[31:0], 32'h11223344);
    cyc(1, 0, nop, 1, 0, 32'h55555555, 1);
    check("stall_res2", s_bus[31:0], 32'h11223344);
    check("stall_allowin2", s_allowin, 1);

    ops = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110};
    for (int j = 0; j < 5; j++)
      ld[j] = mk(32'h1c000100 + 4 * j, 1, 1, ops[j], 1, 5'(j + 8),
                 32'h4000 + j);
    cyc(1, 1, ld[0], 1, 0, '0, 1);
    for (int j = 1; j < 5; j++) begin
      cyc(1, 1, ld[j], 1, 1, $urandom, 1);
      check("b2b_valid", s_valid, 1);
      check("b2b_allowin", s_allowin, 1);
    end
    cyc(1, 0, nop, 1, 1, $urandom, 1);
    check("b2b_last_valid", s_valid, 1);

    for (int n = 0; n < 3000; n++) begin
      ev = ($urandom_range(0, 9) < 7);
      ws = ($urandom_range(0, 3) != 0);
      k = $urandom_range(0, 2);
      r = mk($urandom, 0, 0, 3'($urandom), 1'($urandom), 5'($urandom),
             $urandom);
      if (k == 1) begin
        r.res = 1; r.mreq = 1; r.we = 1;
      end else if (k == 2) begin
        r.mreq = 1; r.we = 0;
      end
      dok = 0;
      if (m_valid && m_ins.mreq && !m_got) begin
        if (m_wait == 0) dok = 1;
        else m_wait--;
      end
      cyc(1, ev, r, ws, dok, $urandom, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
